// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes and modulo-sequencer state encoding.
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_SUB   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        SUB   = ST_SUB,
        DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/alu_mod_sequencer_if.sv
// alu_mod_sequencer_if: request/response and ALU op-select signals of the modulo sequencer.
interface alu_mod_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output start, a_in, b_in, alu_result,
        input  busy, done, result, err, alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, a_in, b_in, alu_result,
        output busy, done, result, err, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu.sv
// alu: combinational 3-bit-op ALU; MOD is multi-cycle and produced by the sequencer instead.
import alu_pkg::*;

module alu #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            OP_LT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_mod_sequencer.sv
// alu_mod_sequencer: computes A mod B by repeated LT/SUB through the shared ALU.
import alu_pkg::*;

module alu_mod_sequencer #(parameter int WIDTH = 32) (
    input logic                 clk,
    input logic                 reset,
    alu_mod_sequencer_if.slave  bus
);
    state_t           state, nxt;
    logic [WIDTH-1:0] r, d, result;
    logic             err, bad;

    assign bad = bus.b_in == '0 || bus.a_in[WIDTH-1] || bus.b_in[WIDTH-1];

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? (bad ? DONE : CHECK) : IDLE;
            CHECK:   nxt = bus.alu_result[0] ? DONE : SUB;
            SUB:     nxt = CHECK;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            r      <= '0;
            d      <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                r   <= bus.a_in;
                d   <= bus.b_in;
                err <= bad;
                if (bad) result <= '0;
            end
            if (state == CHECK && bus.alu_result[0]) result <= r;
            if (state == SUB) r <= bus.alu_result;
        end
    end

    // ALU operands are always the live remainder and divisor registers
    assign bus.alu_a  = r;
    assign bus.alu_b  = d;
    assign bus.alu_op = state == CHECK ? OP_LT : state == SUB ? OP_SUB : OP_AND;
    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = result;
    assign bus.err    = err;
endmodule

// File: tb/tb_alu_mod_sequencer.sv
// tb_alu_mod_sequencer: directed and random modulo requests checked against an arithmetic model.
import alu_pkg::*;

module tb_alu_mod_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    alu_mod_sequencer_if #(.WIDTH(32)) bus ();

    alu_mod_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu #(.WIDTH(32)) u_alu (
        .a  (bus.alu_a),
        .b  (bus.alu_b),
        .op (bus.alu_op),
        .y  (bus.alu_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: q = a/b, done after 2q+2 edges (accept edge counted as 1), ops alternate LT/SUB ending on LT.
    task automatic run(input logic [31:0] a, input logic [31:0] b);
        logic        e;
        int          q, lat;
        logic [31:0] exp;
        e   = b == 0 || a[31] || b[31];
        q   = e ? 0 : int'(a / b);
        exp = e ? 32'd0 : a % b;
        lat = e ? 1 : 2 * q + 2;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_op", bus.alu_op, OP_AND);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("alu_a", bus.alu_a, a);
                chk("alu_b", bus.alu_b, b);
            end
            chk("busy", bus.busy, k <= lat);
            chk("done", bus.done, k == lat);
            chk("op", bus.alu_op, k >= lat ? OP_AND : (k % 2 == 1 ? OP_LT : OP_SUB));
            if (k >= lat) begin
                chk("result", bus.result, exp);
                chk("err", bus.err, e);
            end
            bus.start = 1'b0;
            bus.a_in  = $urandom;
            bus.b_in  = $urandom;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int ph;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_op", bus.alu_op, OP_AND);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        reset = 1'b0;

        run(32'd7, 32'd3);
        run(32'd2, 32'd5);
        run(32'd9, 32'd0);
        run(32'd9, 32'd9);
        run(32'h8000_0000, 32'd3);
        run(32'd5, 32'h8000_0001);
        run(32'd0, 32'd4);

        // Reset during the third SUB drops the request
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("pre_rst_op", bus.alu_op, k % 2 == 1 ? OP_LT : OP_SUB);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_result", bus.result, 0);
        chk("mid_rst_op", bus.alu_op, OP_AND);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        run(32'd100, 32'd7);

        // start held high: accepts at edges 1 and 8, done at 6 and 13
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd10;
        bus.b_in  = 32'd4;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            ph = k <= 7 ? k : k - 7;
            chk("held_busy", bus.busy, k <= 13 && ph <= 6);
            chk("held_done", bus.done, k <= 13 && ph == 6);
            if (k == 6 || k == 13) chk("held_result", bus.result, 32'd2);
            if (k == 13) bus.start = 1'b0;
        end

        repeat (25) begin
            ra = $urandom_range(0, 400);
            rb = $urandom_range(0, 25);
            if ($urandom_range(0, 7) == 0) ra[31] = 1'b1;
            if ($urandom_range(0, 7) == 0) rb[31] = 1'b1;
            run(ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
